dmem_request_ctrl: RTL and testbench
====================================

// Module: dmem_request_ctrl
// PURPOSE
//   CPU-side initiator for a multi-cycle data memory. Accepts MEM-stage
//   load/store commands, issues one request per access over a req/ack
//   handshake, and stalls the pipeline until the access completes.
//   Captures load data for write-back. Sits between the MEM stage and Data_Memory_mc.
// PARAMETERS
//   ADDR_W   32   address width (bytes); word aligned, addr[1:0] must be 0
//   DATA_W   32   data word width
//   TIMEOUT  255  max BUSY cycles waiting for ack; 0 disables timeout
// PORTS
//   clk_i       in   1       clock; all state updates on posedge
//   rst_i       in   1       synchronous reset, active-high
//   MemRead_i   in   1       load command from MEM stage
//   MemWrite_i  in   1       store command from MEM stage
//   addr_i      in   ADDR_W  byte address of access
//   data_i      in   DATA_W  store data
//   data_o      out  DATA_W  load data, valid in DONE cycle, held until next load completes
//   stall_o     out  1       freeze pipeline (combinational)
//   err_o       out  1       1-cycle pulse: misaligned access or timeout
//   mem_req_o   out  1       request to memory, held until ack sampled
//   mem_we_o    out  1       1 = write, 0 = read; stable while mem_req_o=1
//   mem_addr_o  out  ADDR_W  latched address; stable while mem_req_o=1
//   mem_data_o  out  DATA_W  latched store data; stable while mem_req_o=1
//   mem_ack_i   in   1       memory completion, 1 cycle
//   mem_data_i  in   DATA_W  read data, valid with mem_ack_i
// BEHAVIOUR
//   Reset (rst_i=1 at posedge): state=IDLE; mem_req_o, mem_we_o, err_o = 0;
//     data_o, mem_addr_o, mem_data_o = 0; timeout count = 0.
//   access = MemRead_i | MemWrite_i. If both are set, treated as a write.
//   States: IDLE, BUSY, DONE.
//   IDLE: access & addr_i[1:0]==0 -> latch addr/data/we -> BUSY; stall_o=1 this cycle.
//     access & misaligned -> stay IDLE, err_o=1 next cycle, no request, stall_o=0.
//     no access -> stay IDLE, stall_o=0.
//   BUSY: mem_req_o=1, stall_o=1, count increments each cycle.
//     mem_ack_i=1 -> DONE; on a read, data_o <= mem_data_i.
//     TIMEOUT!=0 & count==TIMEOUT-1 without ack -> DONE, err_o pulse, data_o <= 0 on read.
//   DONE: mem_req_o=0, stall_o=0; pipeline advances at this edge -> IDLE.
//     The command still present this cycle is NOT re-issued.
//   Latency: minimum 2 stall cycles. Cycle0 IDLE decode, cycle1 BUSY with ack,
//     cycle2 DONE (stall low).
//   mem_ack_i outside BUSY is ignored and does not update data_o.
//   Ack coinciding with the timeout cycle: ack wins, no err_o.
//   Stores never modify data_o.
//   Reset mid-operation: abort to IDLE; mem_req_o drops at that edge.
//     Memory must tolerate an abandoned request.
//   Count width = clog2(TIMEOUT+1); cleared when entering BUSY.
// STRUCTURE
//   Package dmem_pkg: state encoding localparams (IDLE=2'd0, BUSY=2'd1,
//     DONE=2'd2), timeout-count width function.
//   Sub-module dmem_timeout_ctr: clear/enable counter with terminal-count
//     output. FSM, latches and handshake stay in the top module.
// TESTING
//   Load addr=0x10, ack in 1st BUSY cycle, mem_data_i=0xDEADBEEF
//     -> stall high 2 cycles, data_o=0xDEADBEEF in DONE, one request issued.
//   Store addr=0x24, data=0x12345678, ack after 5 cycles
//     -> mem_we_o=1, addr/data stable for 5 cycles, stall high 6 cycles, data_o unchanged.
//   Load addr=0x13 (misaligned) -> no mem_req_o, err_o=1 for 1 cycle, stall_o=0.
//   TIMEOUT=4, no ack -> 4 BUSY cycles, err_o pulse, data_o=0, FSM back to IDLE.
//   rst_i=1 in 2nd BUSY cycle -> mem_req_o=0 next cycle, state IDLE, stall_o=0 if no access.
//   Spurious mem_ack_i=1 in IDLE with mem_data_i=0xFFFFFFFF
//     -> data_o unchanged, no state change.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory request controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package dmem_pkg;

  // Controller state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } dmem_state_e;

  // Width of the BUSY-cycle counter. A disabled timeout (0) still needs one bit.
  function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts BUSY cycles and flags the last allowed cycle before a timeout.
// Latency: count registered; tc is combinational from the current count and en.
// Backpressure: none; clr has priority over en, TERMINAL=0 never asserts tc.
module dmem_timeout_ctr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'((TERMINAL == 0) ? 0 : TERMINAL - 1);

  logic [WIDTH-1:0] count;

  // Clear on entry to BUSY, advance once per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (TERMINAL != 0) && (count == LAST);

endmodule

// File: rtl/dmem_request_ctrl.sv
// MEM-stage initiator: turns load/store commands into one req/ack access to a multi-cycle data memory.
// Latency: decode cycle + one BUSY cycle per wait state + DONE; minimum 2 stall cycles.
// Backpressure: stall_o freezes the pipeline from decode until DONE; mem_req_o held until ack or timeout.
module dmem_request_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int unsigned CNT_W = tmo_cnt_width(TIMEOUT);

  dmem_state_e state_q;
  dmem_state_e state_d;

  logic access;
  logic aligned;
  logic start;
  logic misalign_err;
  logic ack_done;
  logic tmo_done;
  logic tmo_tc;

  // Both commands together are a store; only word-aligned accesses go to memory
  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (addr_i[1:0] == 2'b00);

  dmem_timeout_ctr #(
    .WIDTH    (CNT_W),
    .TERMINAL (TIMEOUT)
  ) u_tmo (
    .clk (clk_i),
    .rst (rst_i),
    .clr (start),
    .en  (state_q == BUSY),
    .tc  (tmo_tc)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and request; ack beats a coincident timeout
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    mem_req_o    = 1'b0;
    start        = 1'b0;
    misalign_err = 1'b0;
    ack_done     = 1'b0;
    tmo_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          start   = 1'b1;
          stall_o = 1'b1;
          state_d = BUSY;
        end else if (access) begin
          misalign_err = 1'b1;
        end
      end
      BUSY: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end else if (tmo_tc) begin
          tmo_done = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // The pipeline advances on this edge; the command still visible is already served
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latches, load-data capture and the one-cycle error pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      data_o     <= '0;
      err_o      <= 1'b0;
    end else begin
      err_o <= misalign_err | tmo_done;
      if (start) begin
        mem_we_o   <= MemWrite_i;
        mem_addr_o <= addr_i;
        mem_data_o <= data_i;
      end
      if (ack_done && !mem_we_o) begin
        data_o <= mem_data_i;
      end else if (tmo_done && !mem_we_o) begin
        data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_request_ctrl.sv
// Randomized self-checking bench for dmem_request_ctrl against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: bench holds the command while stall_o is high, as the MEM stage would.
module tb_dmem_request_ctrl;

  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] model_data;

  always #5 clk = ~clk;

  dmem_request_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .err_o      (err_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive point: just after the rising edge. Check point: falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One cycle with no command; an ack here must be ignored
  task automatic idle_cycle(input logic ack, input logic [31:0] md, input logic exp_err);
    tick();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    addr_i     = $urandom;
    data_i     = $urandom;
    mem_ack_i  = ack;
    mem_data_i = md;
    sample();
    chk("idle_stall", stall_o, 0);
    chk("idle_req", mem_req_o, 0);
    chk("idle_err", err_o, exp_err);
    chk("idle_data", data_o, model_data);
  endtask

  // One MEM-stage command. ack_dly = BUSY cycle carrying the ack (1 = first); 0 = never.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] rdata, input int ack_dly);
    logic acc;
    logic tmo;
    int   busy_len;
    acc = rd | wr;
    tmo = (ack_dly == 0) || (ack_dly > TMO);
    busy_len = tmo ? TMO : ack_dly;

    tick();
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = addr;
    data_i     = data;
    mem_ack_i  = 1'b0;
    mem_data_i = $urandom;
    sample();
    chk("dec_err", err_o, 0);
    chk("dec_req", mem_req_o, 0);
    if (!acc) begin
      chk("noacc_stall", stall_o, 0);
      return;
    end
    if (addr[1:0] != 2'b00) begin
      chk("mis_stall", stall_o, 0);
      idle_cycle(1'b0, $urandom, 1'b1);
      return;
    end
    chk("dec_stall", stall_o, 1);

    for (int j = 1; j <= busy_len; j++) begin
      tick();
      addr_i     = $urandom;
      data_i     = $urandom;
      mem_ack_i  = (j == ack_dly);
      mem_data_i = (j == ack_dly) ? rdata : $urandom;
      sample();
      chk("busy_req", mem_req_o, 1);
      chk("busy_stall", stall_o, 1);
      chk("busy_we", mem_we_o, wr);
      chk("busy_addr", mem_addr_o, addr);
      chk("busy_wdata", mem_data_o, data);
      chk("busy_err", err_o, 0);
      chk("busy_rdata", data_o, model_data);
    end

    tick();
    addr_i     = addr;
    data_i     = data;
    mem_ack_i  = (ack_dly == busy_len + 1);
    mem_data_i = $urandom;
    if (!wr) model_data = tmo ? 32'h0 : rdata;
    sample();
    chk("done_stall", stall_o, 0);
    chk("done_req", mem_req_o, 0);
    chk("done_err", err_o, tmo);
    chk("done_rdata", data_o, model_data);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    int          r;
    rst_i      = 1'b1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    addr_i     = '0;
    data_i     = '0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    model_data = '0;

    tick();
    tick();
    rst_i = 1'b0;
    sample();
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_rdata", data_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_data_o, 0);

    // Directed scenarios
    txn(1'b1, 1'b0, 32'h10, $urandom, 32'hDEADBEEF, 1);
    txn(1'b0, 1'b1, 32'h24, 32'h12345678, $urandom, 5);
    txn(1'b1, 1'b0, 32'h13, $urandom, $urandom, 1);
    txn(1'b1, 1'b0, 32'h40, $urandom, $urandom, 0);
    txn(1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, $urandom, 2);
    txn(1'b1, 1'b0, 32'h48, $urandom, 32'h11112222, TMO);
    txn(1'b1, 1'b0, 32'h4C, $urandom, 32'h33334444, TMO + 1);
    txn(1'b1, 1'b0, 32'h50, $urandom, 32'h5555AAAA, 3);
    idle_cycle(1'b1, 32'hFFFFFFFF, 1'b0);
    idle_cycle(1'b0, 32'hFFFFFFFF, 1'b0);

    // Reset during the second BUSY cycle
    tick();
    MemRead_i = 1'b1;
    addr_i    = 32'h80;
    mem_ack_i = 1'b0;
    sample();
    chk("rmid_dec_stall", stall_o, 1);
    tick();
    sample();
    chk("rmid_busy1_req", mem_req_o, 1);
    tick();
    rst_i = 1'b1;
    sample();
    chk("rmid_busy2_req", mem_req_o, 1);
    tick();
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    model_data = '0;
    sample();
    chk("rmid_req", mem_req_o, 0);
    chk("rmid_stall", stall_o, 0);
    chk("rmid_err", err_o, 0);
    chk("rmid_rdata", data_o, 0);
    chk("rmid_addr", mem_addr_o, 0);
    idle_cycle(1'b0, $urandom, 1'b0);

    // Randomized mix of loads, stores, misaligned, idle and spurious acks
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        idle_cycle(1'($urandom_range(0, 1)), $urandom, 1'b0);
      end else begin
        r = $urandom_range(0, 3);
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        txn(r[0], r[1], a, $urandom, $urandom, $urandom_range(0, TMO + 2));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
